// File: rtl/piggy_pkg.sv
// Shared definitions for the piggy-bank coin path: amount width, default eject timing, dispenser states.
// Pure declarations; no logic, latency or backpressure of its own.
package piggy_pkg;

  localparam int AMOUNT_W        = 8;
  localparam int COIN_PULSE_HIGH = 16;
  localparam int COIN_PULSE_LOW  = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2,
    FIN  = 2'd3
  } disp_state_t;

  // Timer must hold max(high,low)-1; never narrower than one bit.
  function automatic int timer_w(input int h, input int l);
    int m;
    int w;
    m = (h > l) ? h : l;
    w = $clog2(m);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/piggy_coin_dispenser_if.sv
// Request/eject bundle between the payout requester and the coin dispenser.
// Requester holds req_valid until req_ready; status lines are driven by the dispenser.
interface piggy_coin_dispenser_if
  import piggy_pkg::*;
#(
  parameter int WIDTH = AMOUNT_W
);
  logic             req_valid;
  logic             req_ready;
  logic [WIDTH-1:0] req_amount;
  logic             abort;
  logic             coin_out;
  logic             busy;
  logic             done;
  logic             aborted;
  logic [WIDTH-1:0] remaining;

  modport slave (
    input  req_valid, req_amount, abort,
    output req_ready, coin_out, busy, done, aborted, remaining
  );

  modport master (
    output req_valid, req_amount, abort,
    input  req_ready, coin_out, busy, done, aborted, remaining
  );
endinterface

// File: rtl/piggy_pulse_timer.sv
// Loadable down-counter with a zero flag; load takes effect next cycle, then counts to 0 and holds.
// No handshake: the owner decides when to load.
module piggy_pulse_timer #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  output logic         o_zero
);

  logic [W-1:0] r_count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (r_count != '0) begin
      r_count <= r_count - W'(1);
    end
  end

  assign o_zero = (r_count == '0);

endmodule

// File: rtl/piggy_coin_dispenser.sv
// Emits one fixed-width high/low pulse per coin of an accepted amount; done N*(H+L)+1 cycles after handshake.
// Accepts a request only when idle (req_ready); abort lets the current pulse finish before ending.
module piggy_coin_dispenser
  import piggy_pkg::*;
#(
  parameter int WIDTH      = AMOUNT_W,
  parameter int PULSE_HIGH = COIN_PULSE_HIGH,
  parameter int PULSE_LOW  = COIN_PULSE_LOW
) (
  input  logic                   clk,
  input  logic                   reset,
  piggy_coin_dispenser_if.slave  bus
);

  localparam int            TW     = timer_w(PULSE_HIGH, PULSE_LOW);
  localparam logic [TW-1:0] H_LOAD = TW'(PULSE_HIGH - 1);
  localparam logic [TW-1:0] L_LOAD = TW'(PULSE_LOW - 1);

  disp_state_t      r_state;
  disp_state_t      w_next;
  logic             r_coin;
  logic             r_pend;
  logic [WIDTH-1:0] r_remaining;

  logic             w_pend;
  logic             w_accept;
  logic             w_dec;
  logic             w_tmr_load;
  logic [TW-1:0]    w_tmr_val;
  logic             w_tmr_zero;

  piggy_pulse_timer #(
    .W (TW)
  ) u_timer (
    .clk        (clk),
    .reset      (reset),
    .i_load     (w_tmr_load),
    .i_load_val (w_tmr_val),
    .o_zero     (w_tmr_zero)
  );

  // Abort seen this cycle counts immediately, so an abort in the last LOW cycle still ends the payout.
  assign w_pend = r_pend | (bus.abort & ((r_state == HIGH) | (r_state == LOW)));

  always_comb begin
    w_next     = r_state;
    w_accept   = 1'b0;
    w_dec      = 1'b0;
    w_tmr_load = 1'b0;
    w_tmr_val  = '0;
    case (r_state)
      IDLE: begin
        if (bus.req_valid) begin
          w_accept = 1'b1;
          if (bus.req_amount == '0) begin
            w_next = FIN;
          end else begin
            w_next     = HIGH;
            w_tmr_load = 1'b1;
            w_tmr_val  = H_LOAD;
          end
        end
      end
      HIGH: begin
        if (w_tmr_zero) begin
          w_dec      = 1'b1;
          w_next     = LOW;
          w_tmr_load = 1'b1;
          w_tmr_val  = L_LOAD;
        end
      end
      LOW: begin
        if (w_tmr_zero) begin
          if ((r_remaining == '0) || w_pend) begin
            w_next = FIN;
          end else begin
            w_next     = HIGH;
            w_tmr_load = 1'b1;
            w_tmr_val  = H_LOAD;
          end
        end
      end
      FIN:     w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_coin      <= 1'b0;
      r_pend      <= 1'b0;
      r_remaining <= '0;
    end else begin
      r_state <= w_next;
      r_coin  <= (w_next == HIGH);
      r_pend  <= (r_state == FIN) ? 1'b0 : w_pend;
      if (w_accept) begin
        r_remaining <= bus.req_amount;
      end else if (w_dec && (r_remaining != '0)) begin
        r_remaining <= r_remaining - WIDTH'(1);
      end
    end
  end

  assign bus.req_ready = (r_state == IDLE);
  assign bus.coin_out  = r_coin;
  assign bus.busy      = (r_state != IDLE);
  assign bus.done      = (r_state == FIN);
  assign bus.aborted   = (r_state == FIN) & r_pend;
  assign bus.remaining = r_remaining;

endmodule

// File: doc/piggy_coin_dispenser.md
# piggy_coin_dispenser

Transmit side of the piggy-bank coin interface. The counter/debouncer path receives coin pulses from the slot. This block produces them: given an amount to pay out, it drives a clean pulse train on a hopper/coin-eject line, one pulse per coin. High and low widths are fixed so a downstream debouncer always accepts every pulse. It sits beside the coin counter in the top level and is fed by the change request from the counter.

## Interface
Parameters:
- `WIDTH`, 8: width of amount and remaining count.
- `PULSE_HIGH`, 16: cycles `coin_out` is held high per coin; minimum 1.
- `PULSE_LOW`, 16: cycles `coin_out` is held low after each coin; minimum 1.

Ports:
- `clk`, in, 1: single clock; all state on rising edge.
- `reset`, in, 1: asynchronous, active-high; clears all state immediately.
- `req_valid`, in, 1: payout request present.
- `req_ready`, out, 1: block idle and able to accept a request.
- `req_amount`, in, WIDTH: number of coins to emit; sampled on handshake.
- `abort`, in, 1: stop the payout after the current pulse.
- `coin_out`, out, 1: eject pulse line, registered.
- `busy`, out, 1: high from handshake until `done`.
- `done`, out, 1: one-cycle strobe when a payout ends, whether complete, zero or aborted.
- `aborted`, out, 1: valid with `done`; set if the payout ended by abort.
- `remaining`, out, WIDTH: coins still to emit.

## Operation
- FSM states are IDLE, HIGH, LOW, FIN.
- **IDLE:** `req_ready`=1. On `req_valid && req_ready`, latch `req_amount` into `remaining`.
  - Amount 0 goes to FIN.
  - Otherwise go to HIGH and load the timer with `PULSE_HIGH-1`.
- **HIGH:** `coin_out`=1. The timer counts down.
  - At 0, decrement `remaining` and go to LOW, loading `PULSE_LOW-1`.
- **LOW:** `coin_out`=0. At timer 0:
  - Go to FIN if `remaining`==0 or an abort is pending.
  - Otherwise go to HIGH.
- **FIN:** `done`=1 for one cycle, `aborted` = abort pending, clear the pending flag, then go to IDLE.
- **Abort:**
  - `abort` sampled in HIGH or LOW sets a sticky pending flag.
  - A pulse in progress is never truncated; the current HIGH and LOW complete.
  - `abort` in IDLE or FIN is ignored.
  - `remaining` holds the unpaid count through FIN and IDLE until the next handshake.
- `req_valid` while busy is ignored. There is no queueing, and the requester must hold valid until ready.
- `remaining` decrements exactly once per pulse, at the HIGH→LOW transition. It never wraps below 0.
- **Reset values:** state IDLE, `coin_out`=0, `busy`=0, `done`=0, `aborted`=0, `remaining`=0, timer=0, pending flag=0. `req_ready` is 1 once reset deasserts.
- **Reset mid-pulse:** `coin_out` drops asynchronously and the payout is lost; no `done` is issued.

## Timing
- Handshake at edge T0. `coin_out` rises at T0+1 and `busy` is 1 from T0+1.
- Each coin takes exactly `PULSE_HIGH`+`PULSE_LOW` cycles.
- For N≥1 coins with no abort, `done` is high in cycle T0+1+N·(H+L). `req_ready` returns the next cycle.
- For N=0, `done` is high at T0+1 and there are no pulses.
- Earliest back-to-back request: accepted on the cycle after `done`.
- All outputs are registered or decoded from registered state only; there are no combinational paths from inputs to outputs except `req_ready`, which is decoded from state.
- **Width rule:** timer width is `$clog2(max(PULSE_HIGH,PULSE_LOW))`, minimum 1.

## Structure
- Shared package `piggy_pkg`:
  - state enum `disp_state_t` (IDLE/HIGH/LOW/FIN);
  - default constants `COIN_PULSE_HIGH`/`COIN_PULSE_LOW`;
  - `AMOUNT_W`=8, shared with the coin counter.
- One sub-module, `piggy_pulse_timer`: a loadable down-counter with a zero flag, reused for both HIGH and LOW phases.
- The top-level FSM, remaining counter and abort flag live in `piggy_coin_dispenser`.

## Test plan
All scenarios use `PULSE_HIGH`=3 and `PULSE_LOW`=2.
- Reset, then request amount 3:
  - exactly 3 pulses, each 3 high and 2 low;
  - `remaining` steps 3→2→1→0;
  - `done` is high 16 cycles after the handshake, with `aborted`=0.
- Request amount 0: no `coin_out` activity, `done` at T0+1, `req_ready` back at T0+2.
- Request amount 5, assert `abort` for 1 cycle during the 2nd HIGH:
  - the 2nd pulse completes at full width;
  - `done` with `aborted`=1, `remaining`=3, total 2 pulses.
- Assert `req_valid` with amount 9 while busy with amount 2: it is ignored, only 2 pulses are emitted, and `remaining` never shows 9.
- Assert `reset` in the middle of the 2nd HIGH of amount 4:
  - `coin_out` falls the same cycle;
  - `done` is never asserted;
  - all outputs return to their reset values;
  - a new request is accepted after release.
- Request amount 255:
  - 255 pulses;
  - the pulse count from a debouncer+counter model equals 255;
  - `remaining` ends at 0 without wrapping.
